serial_subtractor16: RTL and testbench

- Bit-serial subtractor; the inverse of the team's 16-bit ripple-carry adder.
- Computes diff = a - b - bin over WIDTH clock cycles, LSB first, using a single full-subtractor cell and a registered borrow.
- Start/busy/done handshake. Sits beside the adder in the arithmetic datapath and is checked against it (a = diff + b + bin).

---
 rtl/serial_subtractor16_if.sv | 18 +
 rtl/serial_subtractor16.sv | 89 ++++++++
 tb/tb_serial_subtractor16.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor16_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
interface serial_subtractor16_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, zero, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero, ovf);
endinterface

// File: rtl/serial_subtractor16.sv
// Bit-serial a - b - bin: one full-subtractor cell, LSB first, WIDTH cycles per operation.
module serial_subtractor16 #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor16_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] r_sh;
  logic             brw, a_msb, b_msb;
  logic [CW-1:0]    cnt;
  logic             d, brw_nxt, last;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, zero_q, ovf_q;

  always_comb begin
    d       = a_sh[0] ^ b_sh[0] ^ brw;
    brw_nxt = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & brw) | (b_sh[0] & brw);
    res     = {d, r_sh};
    last    = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Working registers only move in IDLE (latch) and RUN (shift); results only on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      brw    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        a_sh  <= bus.a;
        b_sh  <= bus.b;
        brw   <= bus.bin;
        a_msb <= bus.a[WIDTH-1];
        b_msb <= bus.b[WIDTH-1];
        cnt   <= '0;
      end
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= res[WIDTH-1:1];
      brw  <= brw_nxt;
      cnt  <= cnt + CW'(1);
      if (last) begin
        diff_q <= res;
        bout_q <= brw_nxt;
        zero_q <= (res == '0);
        ovf_q  <= (a_msb != b_msb) && (d != a_msb);
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor16.sv
// Directed and randomized checks of serial_subtractor16 against hand values and a ripple adder.
module tb_serial_subtractor16;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  serial_subtractor16_if #(.WIDTH(W)) bus ();
  serial_subtractor16 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [W:0] ripple_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] s;
    logic c;
    c = ci;
    for (int i = 0; i < W; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    s[W] = c;
    return s;
  endfunction

  // Presents operands in IDLE, returns #1 after the start edge with start dropped.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    @(negedge clk);
    while (bus.busy || bus.done) @(negedge clk);
    bus.a = av; bus.b = bv; bus.bin = bi; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int busy_n);
    n = 0; busy_n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.busy) busy_n++;
      if (bus.done) break;
    end
    if (!bus.done) begin
      vec_cnt++; err_cnt++;
      $display("FAIL done_timeout: no done after %0d edges, required within 40", n);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; vec_cnt++;
    if ({bus.busy, bus.done, bus.diff, bus.bout, bus.zero, bus.ovf} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b zero=%b ovf=%b, required all 0",
               bus.busy, bus.done, bus.diff, bus.bout, bus.zero, bus.ovf);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n, bn;
    launch(16'd30, 16'd20, 1'b0);
    vec_cnt++;
    if (bus.busy !== 1'b1) begin err_cnt++; $display("FAIL busy_after_start: got %b, required 1", bus.busy); end
    wait_done(n, bn);
    vec_cnt++;
    if (n !== 16) begin err_cnt++; $display("FAIL done_latency: got %0d edges, required 16", n); end
    vec_cnt++;
    if (bn !== 15) begin err_cnt++; $display("FAIL busy_cycles: got %0d after start edge, required 15", bn); end
    vec_cnt++;
    if ({bus.diff, bus.bout, bus.zero, bus.ovf} !== {16'd10, 3'b000}) begin
      err_cnt++;
      $display("FAIL sub_30_20: got diff=%0d bout=%b zero=%b ovf=%b, required 10 0 0 0", bus.diff, bus.bout, bus.zero, bus.ovf);
    end
    @(posedge clk); #1; vec_cnt++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      err_cnt++; $display("FAIL done_one_cycle: got done=%b busy=%b, required 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_borrow_zero();
    int n, bn;
    launch(16'd20, 16'd30, 1'b0); wait_done(n, bn); vec_cnt++;
    if ({bus.diff, bus.bout, bus.zero, bus.ovf} !== {16'hFFF6, 3'b100}) begin
      err_cnt++; $display("FAIL sub_20_30: got diff=%h bout=%b zero=%b ovf=%b, required fff6 1 0 0", bus.diff, bus.bout, bus.zero, bus.ovf);
    end
    launch(16'd5, 16'd5, 1'b0); wait_done(n, bn); vec_cnt++;
    if ({bus.diff, bus.bout, bus.zero, bus.ovf} !== {16'h0000, 3'b010}) begin
      err_cnt++; $display("FAIL sub_5_5: got diff=%h bout=%b zero=%b ovf=%b, required 0000 0 1 0", bus.diff, bus.bout, bus.zero, bus.ovf);
    end
  endtask

  task automatic test_overflow();
    int n, bn;
    launch(16'h8000, 16'h0001, 1'b0); wait_done(n, bn); vec_cnt++;
    if ({bus.diff, bus.bout, bus.zero, bus.ovf} !== {16'h7FFF, 3'b001}) begin
      err_cnt++; $display("FAIL ovf_8000_1: got diff=%h bout=%b zero=%b ovf=%b, required 7fff 0 0 1", bus.diff, bus.bout, bus.zero, bus.ovf);
    end
    launch(16'h7FFF, 16'hFFFF, 1'b0); wait_done(n, bn); vec_cnt++;
    if ({bus.diff, bus.bout, bus.zero, bus.ovf} !== {16'h8000, 3'b101}) begin
      err_cnt++; $display("FAIL ovf_7fff_ffff: got diff=%h bout=%b zero=%b ovf=%b, required 8000 1 0 1", bus.diff, bus.bout, bus.zero, bus.ovf);
    end
  endtask

  task automatic test_bin();
    int n, bn;
    launch(16'd0, 16'd0, 1'b1); wait_done(n, bn); vec_cnt++;
    if ({bus.diff, bus.bout, bus.zero, bus.ovf} !== {16'hFFFF, 3'b100}) begin
      err_cnt++; $display("FAIL bin_0_0: got diff=%h bout=%b zero=%b ovf=%b, required ffff 1 0 0", bus.diff, bus.bout, bus.zero, bus.ovf);
    end
    launch(16'd1111, 16'd111, 1'b1); wait_done(n, bn); vec_cnt++;
    if ({bus.diff, bus.bout} !== {16'd999, 1'b0}) begin
      err_cnt++; $display("FAIL bin_1111_111: got diff=%0d bout=%b, required 999 0", bus.diff, bus.bout);
    end
    launch(16'h1234, 16'h1234, 1'b1); wait_done(n, bn); vec_cnt++;
    if ({bus.diff, bus.bout} !== {16'hFFFF, 1'b1}) begin
      err_cnt++; $display("FAIL bin_equal: got diff=%h bout=%b, required ffff 1", bus.diff, bus.bout);
    end
  endtask

  task automatic test_ignored_start();
    int n, bn;
    launch(16'd1000, 16'd1, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.a = 16'd7; bus.b = 16'd3; bus.bin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    wait_done(n, bn); vec_cnt++;
    if (bus.diff !== 16'd999) begin
      err_cnt++; $display("FAIL ignored_start: got diff=%0d, required 999", bus.diff);
    end
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.bin = 1'b0;
    repeat (4) @(posedge clk);
    #1; vec_cnt++;
    if ({bus.diff, bus.done, bus.busy} !== {16'd999, 2'b00}) begin
      err_cnt++; $display("FAIL result_hold: got diff=%0d done=%b busy=%b, required 999 0 0", bus.diff, bus.done, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int n, bn;
    @(negedge clk);
    bus.a = 16'd50; bus.b = 16'd8; bus.bin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.a = 16'd9; bus.b = 16'd4; bus.bin = 1'b1;
    wait_done(n, bn); vec_cnt++;
    if (bus.diff !== 16'd42) begin err_cnt++; $display("FAIL b2b_first: got diff=%0d, required 42", bus.diff); end
    wait_done(n, bn); vec_cnt++;
    if (n !== 18 || bus.diff !== 16'd4) begin
      err_cnt++; $display("FAIL b2b_second: got diff=%0d after %0d edges, required 4 after 18", bus.diff, n);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset_abort();
    int n, bn, seen;
    launch(16'hF0F0, 16'h0101, 1'b0);
    repeat (7) @(posedge clk);
    #1; rst_n = 1'b0; #1; vec_cnt++;
    if ({bus.busy, bus.done, bus.diff, bus.bout, bus.zero, bus.ovf} !== '0) begin
      err_cnt++;
      $display("FAIL reset_abort: got busy=%b done=%b diff=%h bout=%b zero=%b ovf=%b, required all 0",
               bus.busy, bus.done, bus.diff, bus.bout, bus.zero, bus.ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.done || bus.busy) seen++; end
    vec_cnt++;
    if (seen !== 0) begin err_cnt++; $display("FAIL abort_no_done: got %0d active cycles, required 0", seen); end
    launch(16'd321, 16'd123, 1'b0); wait_done(n, bn); vec_cnt++;
    if (bus.diff !== 16'd198) begin err_cnt++; $display("FAIL after_reset: got diff=%0d, required 198", bus.diff); end
  endtask

  task automatic test_random();
    int n, bn, sx;
    logic [W-1:0] av, bv;
    logic bi;
    logic [W:0] sum;
    for (int i = 0; i < 24; i++) begin
      av = W'($urandom); bv = W'($urandom); bi = 1'($urandom);
      launch(av, bv, bi); wait_done(n, bn);
      sum = ripple_add(bus.diff, bv, bi);
      sx  = $signed(av) - $signed(bv) - int'(bi);
      vec_cnt++;
      if (sum[W-1:0] !== av || bus.bout !== (int'(av) < int'(bv) + int'(bi)) ||
          bus.ovf !== (sx > 32767 || sx < -32768) || bus.zero !== (bus.diff == '0)) begin
        err_cnt++;
        $display("FAIL random_%0d: a=%h b=%h bin=%b got diff=%h bout=%b ovf=%b zero=%b, required diff+b+bin=%h",
                 i, av, bv, bi, bus.diff, bus.bout, bus.ovf, bus.zero, av);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_zero();
    test_overflow();
    test_bin();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
